// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational 16x16->32 unsigned Wallace-tree multiplier among
//   N_REQ requesters. Round-robin arbitration, one operation in flight.
//
//   Optional build macro MULT_PIPE_EN: adds a register on the multiplier
//   output and a CALC2 state between CALC and RESP (one extra cycle of latency).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (combinational in IDLE, at most one high)
//   req_A/B    operands, requester i on bits [16i+15:16i]
//   rsp_valid  response valid, held until rsp_ready
//   rsp_ready  response consumer ready
//   rsp_id     index of the requester owning the response
//   rsp_Z      full 32-bit product
//   op_count   completed responses, wraps modulo 2^16
module mult_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_A,
    input  logic [16*N_REQ-1:0]   req_B,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_Z,
    output logic [15:0]           op_count
);

    localparam int unsigned OP_W  = 16;
    localparam int unsigned Z_W   = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SEL_W = $clog2(N_REQ);
    localparam int unsigned IDX_W = SEL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_RESP
`ifdef MULT_PIPE_EN
        , ST_CALC2
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [Z_W-1:0]     rsp_z_q, rsp_z_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
`ifdef MULT_PIPE_EN
    logic [Z_W-1:0]     pipe_q, pipe_d;
`endif

    logic [OP_W-1:0]    req_a_arr [N_REQ];
    logic [OP_W-1:0]    req_b_arr [N_REQ];
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_sel;
    logic [IDX_W-1:0]   idx;
    logic [Z_W-1:0]     mult_z;

    // Unpack the flat operand buses
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_a_arr[i] = req_A[16*i +: 16];
            req_b_arr[i] = req_B[16*i +: 16];
        end
    end

    // Round-robin search: first valid requester at or after ptr_q, with wrap
    always_comb begin
        grant_vld = 1'b0;
        grant_sel = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + IDX_W'(k);
            if (idx >= IDX_W'(N_REQ)) begin
                idx = idx - IDX_W'(N_REQ);
            end
            if (!grant_vld && req_valid[idx[SEL_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_sel = idx[SEL_W-1:0];
            end
        end
    end

    // Wallace tree: word-level 3:2 compressor layers reduce 16 partial
    // products to two rows (16->11->8->6->4->3->2), then one final add.
    // Carries shifted past bit 31 are dropped; the product fits in 32 bits.
    always_comb begin : wallace_tree
        logic [Z_W-1:0] rows [16];
        logic [Z_W-1:0] x, y, z;
        int unsigned    n_rows, n_out;
        for (int unsigned i = 0; i < 16; i++) begin
            rows[i] = b_q[i] ? (Z_W'(a_q) << i) : '0;
        end
        n_rows = 16;
        x      = '0;
        y      = '0;
        z      = '0;
        for (int unsigned s = 0; s < 6; s++) begin
            n_out = 0;
            for (int unsigned g = 0; g < 5; g++) begin
                if (3*g + 2 < n_rows) begin
                    x = rows[3*g];
                    y = rows[3*g + 1];
                    z = rows[3*g + 2];
                    rows[n_out]     = x ^ y ^ z;
                    rows[n_out + 1] = ((x & y) | (x & z) | (y & z)) << 1;
                    n_out = n_out + 2;
                end
            end
            // Rows left over after grouping by three pass straight through
            for (int unsigned r = 0; r < 16; r++) begin
                if ((r >= (n_rows / 3) * 3) && (r < n_rows)) begin
                    rows[n_out] = rows[r];
                    n_out = n_out + 1;
                end
            end
            n_rows = n_out;
        end
        mult_z = rows[0] + rows[1];
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        op_count_d  = op_count_q;
`ifdef MULT_PIPE_EN
        pipe_d      = pipe_q;
`endif
        req_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_sel] = 1'b1;
                    a_d     = req_a_arr[grant_sel];
                    b_d     = req_b_arr[grant_sel];
                    id_d    = ID_W'(grant_sel);
                    ptr_d   = (grant_sel == SEL_W'(N_REQ - 1)) ? '0 : grant_sel + SEL_W'(1);
                    state_d = ST_CALC;
                end
            end
`ifdef MULT_PIPE_EN
            ST_CALC: begin
                pipe_d  = mult_z;
                state_d = ST_CALC2;
            end
            ST_CALC2: begin
                rsp_z_d     = pipe_q;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
`else
            ST_CALC: begin
                rsp_z_d     = mult_z;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            op_count_q  <= '0;
`ifdef MULT_PIPE_EN
            pipe_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            op_count_q  <= op_count_d;
`ifdef MULT_PIPE_EN
            pipe_q      <= pipe_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_Z     = rsp_z_q;
    assign op_count  = op_count_q;

endmodule
